// File: rtl/spi_slave_shift_engine.sv
// SPI responder engine: oversamples sclk/cs_n/mosi0 on pclk, shifts a buffered TX word
// out on miso0 and returns each completed RX word with a one-cycle rx_valid pulse.
module spi_slave_shift_engine #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  pclk,
    input  logic                  areset,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic                  msb_first,
    input  logic                  sclk,
    input  logic                  cs_n,
    input  logic                  mosi0,
    output logic                  miso0,
    output logic                  miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  tx_underrun,
    output logic                  busy
);
    localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic {IDLE, ACTIVE} state_e;

    state_e                state_q, state_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic                  sclk_prev_q, cs_prev_q;
    logic                  cpol_q, cpol_d, cpha_q, cpha_d, msb_q, msb_d;
    logic [DATA_WIDTH-1:0] tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d;
    logic [DATA_WIDTH-1:0] buf_q, buf_d, rx_data_q, rx_data_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  miso_q, miso_d, tx_ready_q, tx_ready_d;
    logic                  rx_valid_q, rx_valid_d, underrun_q, underrun_d;
    logic                  reload_q, reload_d;
    logic                  sclk_s, cs_s, mosi_s;
    logic                  sclk_edge, lead_edge, trail_edge, sample_edge, shift_edge;
    logic                  cs_fall, cs_rise, take;
    logic [DATA_WIDTH-1:0] load_word, rx_next;

    function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w, input logic msb);
        return msb ? w[DATA_WIDTH-1] : w[0];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] drop_bit(input logic [DATA_WIDTH-1:0] w,
                                                       input logic msb);
        return msb ? (w << 1) : (w >> 1);
    endfunction

    assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s        = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_edge   = sclk_s ^ sclk_prev_q;
    assign lead_edge   = sclk_edge && (sclk_prev_q == cpol_q);
    assign trail_edge  = sclk_edge && (sclk_s == cpol_q);
    assign sample_edge = cpha_q ? trail_edge : lead_edge;
    assign shift_edge  = cpha_q ? lead_edge : trail_edge;
    assign cs_fall     = !cs_s && cs_prev_q;
    assign cs_rise     = cs_s && !cs_prev_q;
    assign load_word   = tx_ready_q ? '0 : buf_q;
    assign rx_next     = msb_q ? {rx_sr_q[DATA_WIDTH-2:0], mosi_s}
                               : {mosi_s, rx_sr_q[DATA_WIDTH-1:1]};

    // Pin synchronizers; cs_n resets deselected so reset release never fakes a select.
    always_ff @(posedge pclk or posedge areset) begin
        if (areset) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi0};
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
        end
    end

    always_ff @(posedge pclk or posedge areset) begin
        if (areset) begin
            state_q    <= IDLE;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            msb_q      <= 1'b1;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            buf_q      <= '0;
            rx_data_q  <= '0;
            cnt_q      <= '0;
            miso_q     <= 1'b0;
            tx_ready_q <= 1'b1;
            rx_valid_q <= 1'b0;
            underrun_q <= 1'b0;
            reload_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            msb_q      <= msb_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            buf_q      <= buf_d;
            rx_data_q  <= rx_data_d;
            cnt_q      <= cnt_d;
            miso_q     <= miso_d;
            tx_ready_q <= tx_ready_d;
            rx_valid_q <= rx_valid_d;
            underrun_q <= underrun_d;
            reload_q   <= reload_d;
        end
    end

    // Reload after a completed word is deferred to the next shift edge, so a word only
    // starts (and can only underrun) once the master actually clocks it.
    always_comb begin
        state_d    = state_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        msb_d      = msb_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        buf_d      = buf_q;
        rx_data_d  = rx_data_q;
        cnt_d      = cnt_q;
        miso_d     = miso_q;
        tx_ready_d = tx_ready_q;
        rx_valid_d = 1'b0;
        underrun_d = 1'b0;
        reload_d   = reload_q;
        take       = 1'b0;

        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d    = ACTIVE;
                    cpol_d     = cpol;
                    cpha_d     = cpha;
                    msb_d      = msb_first;
                    cnt_d      = '0;
                    rx_sr_d    = '0;
                    reload_d   = 1'b0;
                    take       = 1'b1;
                    underrun_d = tx_ready_q;
                    if (cpha) begin
                        tx_sr_d = load_word;
                        miso_d  = 1'b0;
                    end else begin
                        miso_d  = first_bit(load_word, msb_first);
                        tx_sr_d = drop_bit(load_word, msb_first);
                    end
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    state_d  = IDLE;
                    miso_d   = 1'b0;
                    cnt_d    = '0;
                    reload_d = 1'b0;
                end else if (sample_edge) begin
                    rx_sr_d = rx_next;
                    if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                        rx_data_d  = rx_next;
                        rx_valid_d = 1'b1;
                        cnt_d      = '0;
                        reload_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (shift_edge) begin
                    if (reload_q) begin
                        take       = 1'b1;
                        underrun_d = tx_ready_q;
                        reload_d   = 1'b0;
                        miso_d     = first_bit(load_word, msb_q);
                        tx_sr_d    = drop_bit(load_word, msb_q);
                    end else begin
                        miso_d  = first_bit(tx_sr_q, msb_q);
                        tx_sr_d = drop_bit(tx_sr_q, msb_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A write landing in the same cycle the buffer drains is kept.
        if (take) begin
            tx_ready_d = 1'b1;
        end
        if (tx_valid && (tx_ready_q || take)) begin
            buf_d      = tx_data;
            tx_ready_d = 1'b0;
        end
    end

    assign miso0       = miso_q;
    assign miso_oe     = (state_q == ACTIVE);
    assign busy        = (state_q == ACTIVE);
    assign tx_ready    = tx_ready_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_underrun = underrun_q;
endmodule
